// File: rtl/mem_access_ctrl.sv
// ============================================================================
// Module      : mem_access_ctrl
// Description : Load/store unit bridging a pipeline to a req/gnt/rvalid memory port.
//               It aligns and extends load data and reports access faults.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_ctrl #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    input  logic        req_store,
    input  logic [2:0]  req_type,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int c_cnt_w = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [2:0] c_mt_x  = 3'd0;
    localparam logic [2:0] c_mt_b  = 3'd1;
    localparam logic [2:0] c_mt_h  = 3'd2;
    localparam logic [2:0] c_mt_w  = 3'd3;
    localparam logic [2:0] c_mt_bu = 3'd4;
    localparam logic [2:0] c_mt_hu = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RESP  = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic                 store_q, store_d;
    logic [2:0]           type_q, type_d;
    logic [31:0]          addr_q, addr_d;
    logic [c_cnt_w-1:0]   cnt_q, cnt_d;
    logic                 mem_req_q, mem_req_d;
    logic [3:0]           mem_be_q, mem_be_d;
    logic [31:0]          mem_wdata_q, mem_wdata_d;
    logic                 resp_valid_q, resp_valid_d;
    logic                 resp_fault_q, resp_fault_d;
    logic [31:0]          resp_rdata_q, resp_rdata_d;

    logic                 w_legal;
    logic                 w_misaligned;
    logic [31:0]          w_shifted;
    logic [31:0]          w_load_data;

    always_comb begin
        w_legal      = (req_type >= c_mt_b) && (req_type <= c_mt_hu);
        w_misaligned = (((req_type == c_mt_h) || (req_type == c_mt_hu)) && req_addr[0]) ||
                       ((req_type == c_mt_w) && (req_addr[1:0] != 2'b00));
    end

    // Lane 0 of the shifted word always holds the addressed byte/halfword.
    always_comb begin
        w_shifted = mem_rdata >> {addr_q[1:0], 3'b000};
        case (type_q)
            c_mt_b:  w_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            c_mt_bu: w_load_data = {24'd0, w_shifted[7:0]};
            c_mt_h:  w_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            c_mt_hu: w_load_data = {16'd0, w_shifted[15:0]};
            default: w_load_data = w_shifted;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        store_d      = store_q;
        type_d       = type_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        mem_req_d    = 1'b0;
        mem_be_d     = mem_be_q;
        mem_wdata_d  = mem_wdata_q;
        resp_valid_d = 1'b0;
        resp_fault_d = 1'b0;
        resp_rdata_d = 32'd0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && (req_type != c_mt_x)) begin
                    if (!w_legal || w_misaligned) begin
                        state_d      = ST_FAULT;
                        resp_valid_d = 1'b1;
                        resp_fault_d = 1'b1;
                    end else begin
                        state_d   = ST_REQ;
                        mem_req_d = 1'b1;
                        store_d   = req_store;
                        type_d    = req_type;
                        addr_d    = req_addr;
                        case (req_type)
                            c_mt_b, c_mt_bu: begin
                                mem_be_d    = 4'b0001 << req_addr[1:0];
                                mem_wdata_d = {4{req_wdata[7:0]}};
                            end
                            c_mt_h, c_mt_hu: begin
                                mem_be_d    = 4'b0011 << {req_addr[1], 1'b0};
                                mem_wdata_d = {2{req_wdata[15:0]}};
                            end
                            default: begin
                                mem_be_d    = 4'b1111;
                                mem_wdata_d = req_wdata;
                            end
                        endcase
                    end
                end
            end
            ST_REQ: begin
                if (mem_gnt) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end else begin
                    mem_req_d = 1'b1;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid) begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = store_q ? 32'd0 : w_load_data;
                end else if (cnt_q == c_cnt_w'(TIMEOUT_CYCLES - 1)) begin
                    state_d      = ST_FAULT;
                    resp_valid_d = 1'b1;
                    resp_fault_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            store_q      <= 1'b0;
            type_q       <= 3'd0;
            addr_q       <= 32'd0;
            cnt_q        <= '0;
            mem_req_q    <= 1'b0;
            mem_be_q     <= 4'd0;
            mem_wdata_q  <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_fault_q <= 1'b0;
            resp_rdata_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            store_q      <= store_d;
            type_q       <= type_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            mem_req_q    <= mem_req_d;
            mem_be_q     <= mem_be_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_fault_q <= resp_fault_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    // Stall is gated by reset so every output reads zero while reset is held.
    assign stall = reset_n &&
                   (((state_q == ST_IDLE) && req_valid && (req_type != c_mt_x)) ||
                    (state_q == ST_REQ) || (state_q == ST_WAIT));

    assign mem_req    = mem_req_q;
    assign mem_we     = store_q;
    assign mem_addr   = {addr_q[31:2], 2'b00};
    assign mem_be     = mem_be_q;
    assign mem_wdata  = mem_wdata_q;
    assign resp_valid = resp_valid_q;
    assign resp_fault = resp_fault_q;
    assign resp_rdata = resp_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
// ============================================================================
// Module      : tb_mem_access_ctrl
// Description : Directed and randomized self-checking bench for mem_access_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_ctrl;

    localparam int TO = 16;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic        req_store;
    logic [2:0]  req_type;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    mem_access_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_store  (req_store),
        .req_type   (req_type),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .stall      (stall),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_fault (resp_fault),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model: access width in bytes, 0 for MT_X and illegal encodings.
    function automatic int unsigned op_size(input logic [2:0] t);
        case (t)
            3'd1, 3'd4: return 1;
            3'd2, 3'd5: return 2;
            3'd3:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic bit exp_fault(input logic [2:0] t, input logic [31:0] a);
        int unsigned s = op_size(t);
        if (s == 0) return 1'b1;
        return (a % s) != 0;
    endfunction

    function automatic logic [31:0] exp_be(input logic [2:0] t, input logic [31:0] a);
        int unsigned s = op_size(t);
        return 32'(((1 << s) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] t, input logic [31:0] d);
        int unsigned s = op_size(t);
        logic [31:0] r = '0;
        for (int l = 0; l < 4; l++) r[8*l +: 8] = d[8*(l % s) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] exp_rdata(input logic [2:0] t, input logic [31:0] a,
                                              input logic [31:0] d);
        int unsigned s = op_size(t);
        logic [31:0] mask = (s == 4) ? 32'hFFFF_FFFF : 32'((64'd1 << (8*s)) - 1);
        logic [31:0] v    = (d >> (8*(a % 4))) & mask;
        if (((t == 3'd1) || (t == 3'd2)) && v[8*s-1]) v = v | ~mask;
        return v;
    endfunction

    // One complete access; rv_dly >= TO means the memory never answers.
    task automatic access(input bit st, input logic [2:0] t, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd,
                          input int gd, input int rv_dly);
        bit f    = exp_fault(t, a);
        bit done = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_store = st; req_type = t; req_addr = a; req_wdata = wd;
        #1;
        chk("stall_idle", 32'(stall), 32'(t != 3'd0));
        chk("memreq_idle", 32'(mem_req), 32'd0);
        @(negedge clk);
        req_valid = 1'b0; req_type = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
        if (t == 3'd0) begin
            chk("mtx_memreq", 32'(mem_req), 32'd0);
            chk("mtx_resp", 32'(resp_valid), 32'd0);
            return;
        end
        if (f) begin
            chk("flt_valid", 32'(resp_valid), 32'd1);
            chk("flt_fault", 32'(resp_fault), 32'd1);
            chk("flt_rdata", resp_rdata, 32'd0);
            chk("flt_memreq", 32'(mem_req), 32'd0);
            @(negedge clk);
            chk("flt_done", 32'(resp_valid), 32'd0);
            return;
        end
        for (int g = 0; g <= gd; g++) begin
            chk("req_memreq", 32'(mem_req), 32'd1);
            chk("req_stall", 32'(stall), 32'd1);
            chk("req_addr", mem_addr, a & 32'hFFFF_FFFC);
            chk("req_we", 32'(mem_we), 32'(st));
            chk("req_be", 32'(mem_be), exp_be(t, a));
            if (st) chk("req_wdata", mem_wdata, exp_wdata(t, wd));
            mem_gnt = (g == gd);
            @(negedge clk);
        end
        mem_gnt = 1'b0;
        for (int w = 0; w < TO && !done; w++) begin
            chk("wait_memreq", 32'(mem_req), 32'd0);
            chk("wait_stall", 32'(stall), 32'd1);
            chk("wait_resp", 32'(resp_valid), 32'd0);
            if (w == rv_dly) begin
                mem_rvalid = 1'b1; mem_rdata = rd; done = 1'b1;
            end else begin
                mem_rvalid = 1'b0; mem_rdata = $urandom;
            end
            @(negedge clk);
        end
        mem_rvalid = 1'b0;
        chk("resp_valid", 32'(resp_valid), 32'd1);
        chk("resp_fault", 32'(resp_fault), 32'(!done));
        chk("resp_rdata", resp_rdata, (!done || st) ? 32'd0 : exp_rdata(t, a, rd));
        chk("resp_stall", 32'(stall), 32'd0);
        @(negedge clk);
        chk("resp_pulse", 32'(resp_valid), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_type = 3'd0;
        req_addr = '0; req_wdata = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_memreq", 32'(mem_req), 32'd0);
        chk("rst_resp", 32'(resp_valid), 32'd0);
        chk("rst_be", 32'(mem_be), 32'd0);
        reset_n = 1'b1;

        access(1'b0, 3'd1, 32'h1003, 32'h0, 32'h8011_2233, 0, 0);
        access(1'b1, 3'd2, 32'h2002, 32'h0000_BEEF, 32'h1234_5678, 3, 0);
        access(1'b0, 3'd3, 32'h3001, 32'h0, 32'h0, 0, 0);
        access(1'b0, 3'd7, 32'h3000, 32'h0, 32'h0, 0, 0);
        access(1'b0, 3'd0, 32'h5000, 32'h0, 32'h0, 0, 0);
        access(1'b0, 3'd5, 32'h4002, 32'h0, 32'hF00D_0000, 0, TO);
        access(1'b0, 3'd5, 32'h4002, 32'h0, 32'hF00D_0000, 0, TO - 1);

        // Reset asserted while the access sits in WAIT.
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b0; req_type = 3'd3; req_addr = 32'h10;
        @(negedge clk);
        req_valid = 1'b0; mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        chk("mid_stall", 32'(stall), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_stall", 32'(stall), 32'd0);
        chk("mid_rst_memreq", 32'(mem_req), 32'd0);
        chk("mid_rst_resp", 32'(resp_valid), 32'd0);
        chk("mid_rst_be", 32'(mem_be), 32'd0);
        chk("mid_rst_addr", mem_addr, 32'd0);
        @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        reset_n = 1'b1; mem_rvalid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("post_rst_resp", 32'(resp_valid), 32'd0);
        end
        access(1'b0, 3'd3, 32'h0, 32'h0, 32'hCAFE_F00D, 0, 0);

        for (int i = 0; i < 40; i++) begin
            access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
                   $urandom, $urandom_range(0, 3),
                   ($urandom_range(0, 7) == 0) ? TO : $urandom_range(0, 4));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
